// File: rtl/phy_regfile_pkg.sv
// Shared defaults and index/value types for the multi-port physical register file.
package phy_regfile_pkg;
   localparam int DEF_NUM_PREG  = 64;
   localparam int DEF_PREG_W    = $clog2(DEF_NUM_PREG);
   localparam int DEF_VAL_W     = 32;
   localparam int DEF_NUM_RD    = 4;
   localparam int DEF_NUM_WR    = 3;
   localparam int DEF_NUM_ALLOC = 2;

   typedef logic [DEF_PREG_W-1:0] preg_idx_t;
   typedef logic [DEF_VAL_W-1:0]  reg_val_t;
endpackage

// File: rtl/phy_regfile_bypass_rd.sv
// One read port: array value/ready, overridden by the lowest-index write port
// hitting the same register this cycle; preg 0 always reads as zero and ready.
module phy_regfile_bypass_rd
   import phy_regfile_pkg::*;
#(
   parameter int PREG_W = DEF_PREG_W,
   parameter int VAL_W  = DEF_VAL_W,
   parameter int NUM_WR = DEF_NUM_WR
) (
   input  logic [PREG_W-1:0]        rd_preg,
   input  logic [VAL_W-1:0]         arr_val,
   input  logic                     arr_ready,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*PREG_W-1:0] wr_preg,
   input  logic [NUM_WR*VAL_W-1:0]  wr_val,
   output logic [VAL_W-1:0]         rd_val,
   output logic                     rd_ready
);

   always_comb begin
      rd_val   = arr_val;
      rd_ready = arr_ready;
      // Walk from the highest port down so the lowest matching port is applied last.
      for (int j = NUM_WR - 1; j >= 0; j--) begin
         if (wr_en[j] && (wr_preg[j*PREG_W +: PREG_W] == rd_preg)) begin
            rd_val   = wr_val[j*VAL_W +: VAL_W];
            rd_ready = 1'b1;
         end
      end
      if (rd_preg == '0) begin
         rd_val   = '0;
         rd_ready = 1'b1;
      end
   end

endmodule

// File: rtl/phy_regfile_mp.sv
// Multi-port physical register file with per-register ready scoreboard,
// write-to-read bypass and a sticky same-register write collision flag.
module phy_regfile_mp
   import phy_regfile_pkg::*;
#(
   parameter int NUM_PREG  = DEF_NUM_PREG,
   parameter int PREG_W    = $clog2(NUM_PREG),
   parameter int VAL_W     = DEF_VAL_W,
   parameter int NUM_RD    = DEF_NUM_RD,
   parameter int NUM_WR    = DEF_NUM_WR,
   parameter int NUM_ALLOC = DEF_NUM_ALLOC
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_RD*PREG_W-1:0]    rd_preg,
   output logic [NUM_RD*VAL_W-1:0]     rd_val,
   output logic [NUM_RD-1:0]           rd_ready,
   input  logic [NUM_WR-1:0]           wr_en,
   input  logic [NUM_WR*PREG_W-1:0]    wr_preg,
   input  logic [NUM_WR*VAL_W-1:0]     wr_val,
   input  logic [NUM_ALLOC-1:0]        alloc_en,
   input  logic [NUM_ALLOC*PREG_W-1:0] alloc_preg,
   output logic                        wr_conflict
);

   logic [VAL_W-1:0]    mem [NUM_PREG];
   logic [NUM_PREG-1:0] ready;
   logic                collide;

   function automatic logic live_idx(input logic [PREG_W-1:0] p);
      return (p != '0) && (int'(p) < NUM_PREG);
   endfunction

   always_comb begin
      collide = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         for (int k = j + 1; k < NUM_WR; k++) begin
            if (wr_en[j] && wr_en[k] && live_idx(wr_preg[j*PREG_W +: PREG_W]) &&
                (wr_preg[j*PREG_W +: PREG_W] == wr_preg[k*PREG_W +: PREG_W]))
               collide = 1'b1;
         end
      end
   end

   // Writes applied highest port first so the lowest port lands last; allocation
   // clears after the write-sets so it wins the ready bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PREG; p++) mem[p] <= '0;
         ready       <= '1;
         wr_conflict <= 1'b0;
      end else begin
         for (int j = NUM_WR - 1; j >= 0; j--) begin
            if (wr_en[j] && live_idx(wr_preg[j*PREG_W +: PREG_W])) begin
               mem[wr_preg[j*PREG_W +: PREG_W]]   <= wr_val[j*VAL_W +: VAL_W];
               ready[wr_preg[j*PREG_W +: PREG_W]] <= 1'b1;
            end
         end
         for (int k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_en[k] && live_idx(alloc_preg[k*PREG_W +: PREG_W]))
               ready[alloc_preg[k*PREG_W +: PREG_W]] <= 1'b0;
         end
         if (collide) wr_conflict <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [PREG_W-1:0] idx;
      assign idx = rd_preg[i*PREG_W +: PREG_W];

      phy_regfile_bypass_rd #(
         .PREG_W (PREG_W),
         .VAL_W  (VAL_W),
         .NUM_WR (NUM_WR)
      ) u_bypass (
         .rd_preg   (idx),
         .arr_val   (mem[idx]),
         .arr_ready (ready[idx]),
         .wr_en     (wr_en),
         .wr_preg   (wr_preg),
         .wr_val    (wr_val),
         .rd_val    (rd_val[i*VAL_W +: VAL_W]),
         .rd_ready  (rd_ready[i])
      );
   end

endmodule

// File: tb/tb_phy_regfile_mp.sv
// Directed bench for phy_regfile_mp: reset, bypass, scoreboard, collision, preg 0.
module tb_phy_regfile_mp;
   import phy_regfile_pkg::*;

   localparam int PW = DEF_PREG_W;
   localparam int VW = DEF_VAL_W;
   localparam int NR = DEF_NUM_RD;
   localparam int NW = DEF_NUM_WR;
   localparam int NA = DEF_NUM_ALLOC;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*PW-1:0]  rd_preg;
   logic [NR*VW-1:0]  rd_val;
   logic [NR-1:0]     rd_ready;
   logic [NW-1:0]     wr_en;
   logic [NW*PW-1:0]  wr_preg;
   logic [NW*VW-1:0]  wr_val;
   logic [NA-1:0]     alloc_en;
   logic [NA*PW-1:0]  alloc_preg;
   logic              wr_conflict;

   int vectors = 0;
   int miscompares = 0;

   phy_regfile_mp dut (
      .clk         (clk),
      .reset       (reset),
      .rd_preg     (rd_preg),
      .rd_val      (rd_val),
      .rd_ready    (rd_ready),
      .wr_en       (wr_en),
      .wr_preg     (wr_preg),
      .wr_val      (wr_val),
      .alloc_en    (alloc_en),
      .alloc_preg  (alloc_preg),
      .wr_conflict (wr_conflict)
   );

   always #5 clk = ~clk;

   function automatic reg_val_t rv(input int i);
      return rd_val[i*VW +: VW];
   endfunction

   task automatic set_rd(input int i, input preg_idx_t p);
      rd_preg[i*PW +: PW] = p;
   endtask

   task automatic set_wr(input int j, input preg_idx_t p, input reg_val_t v);
      wr_en[j]            = 1'b1;
      wr_preg[j*PW +: PW] = p;
      wr_val[j*VW +: VW]  = v;
   endtask

   task automatic set_alloc(input int k, input preg_idx_t p);
      alloc_en[k]            = 1'b1;
      alloc_preg[k*PW +: PW] = p;
   endtask

   task automatic idle_inputs();
      wr_en    = '0;
      alloc_en = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_val(input string name, input int port, input reg_val_t exp);
      vectors++;
      if (rv(port) !== exp) begin
         miscompares++;
         $display("FAIL %s: rd_val[%0d] got %0d expected %0d", name, port, rv(port), exp);
      end
   endtask

   task automatic chk_rdy(input string name, input int port, input logic exp);
      vectors++;
      if (rd_ready[port] !== exp) begin
         miscompares++;
         $display("FAIL %s: rd_ready[%0d] got %b expected %b", name, port, rd_ready[port], exp);
      end
   endtask

   task automatic chk_conf(input string name, input logic exp);
      vectors++;
      if (wr_conflict !== exp) begin
         miscompares++;
         $display("FAIL %s: wr_conflict got %b expected %b", name, wr_conflict, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rd_preg = '0; wr_preg = '0; wr_val = '0; alloc_preg = '0;
      idle_inputs();
      #20;
      reset = 1'b0;
      #1;
      set_rd(0, 21); set_rd(1, 23);
      #1;
      chk_val("reset_val21", 0, 0);
      chk_rdy("reset_rdy21", 0, 1'b1);
      chk_val("reset_val23", 1, 0);
      chk_rdy("reset_rdy23", 1, 1'b1);
      chk_conf("reset_conflict", 1'b0);
   endtask

   task automatic test_write_readback();
      set_rd(0, 23);
      set_wr(0, 23, 144);
      #1;
      chk_val("wr_bypass_val", 0, 144);
      chk_rdy("wr_bypass_rdy", 0, 1'b1);
      tick();
      idle_inputs();
      #1;
      chk_val("wr_array_val", 0, 144);
      chk_conf("wr_no_conflict", 1'b0);
   endtask

   task automatic test_alloc_ready();
      set_rd(1, 22);
      set_alloc(0, 22);
      #1;
      chk_rdy("alloc_same_cycle_rdy", 1, 1'b1);
      tick();
      idle_inputs();
      #1;
      chk_rdy("alloc_next_rdy", 1, 1'b0);
      set_wr(1, 22, 109);
      #1;
      chk_rdy("wb_bypass_rdy", 1, 1'b1);
      chk_val("wb_bypass_val", 1, 109);
      tick();
      idle_inputs();
      #1;
      chk_rdy("wb_held_rdy", 1, 1'b1);
      chk_val("wb_held_val", 1, 109);
      tick();
      chk_rdy("wb_held2_rdy", 1, 1'b1);
      chk_val("wb_held2_val", 1, 109);
   endtask

   task automatic test_alloc_write_same();
      set_rd(2, 5);
      set_alloc(1, 5);
      set_wr(2, 5, 7);
      tick();
      idle_inputs();
      #1;
      chk_val("allocwr_val", 2, 7);
      chk_rdy("allocwr_rdy", 2, 1'b0);
      // Double allocation of one register is legal and not a conflict.
      set_alloc(0, 30); set_alloc(1, 30);
      set_rd(3, 30);
      tick();
      idle_inputs();
      #1;
      chk_rdy("dual_alloc_rdy", 3, 1'b0);
      chk_conf("dual_alloc_conflict", 1'b0);
   endtask

   task automatic test_preg0();
      for (int j = 0; j < NW; j++) set_wr(j, 0, 55);
      set_alloc(0, 0); set_alloc(1, 0);
      set_rd(2, 0);
      #1;
      chk_val("p0_bypass_val", 2, 0);
      chk_rdy("p0_bypass_rdy", 2, 1'b1);
      tick();
      idle_inputs();
      #1;
      chk_val("p0_array_val", 2, 0);
      chk_rdy("p0_array_rdy", 2, 1'b1);
      chk_conf("p0_no_conflict", 1'b0);
   endtask

   task automatic test_collision();
      set_rd(3, 9);
      set_wr(0, 9, 11);
      set_wr(2, 9, 33);
      #1;
      chk_val("coll_bypass_val", 3, 11);
      chk_conf("coll_before_edge", 1'b0);
      tick();
      idle_inputs();
      #1;
      chk_val("coll_stored_val", 3, 11);
      chk_conf("coll_flag", 1'b1);
      tick();
      tick();
      chk_conf("coll_sticky", 1'b1);
   endtask

   task automatic test_mid_reset();
      set_rd(0, 23); set_rd(1, 5); set_rd(2, 22);
      set_rd(3, 40);
      set_wr(0, 40, 77);
      #1;
      reset = 1'b1;
      #1;
      chk_val("midrst_val23", 0, 0);
      chk_rdy("midrst_rdy5", 1, 1'b1);
      chk_val("midrst_val22", 2, 0);
      chk_val("midrst_bypass", 3, 77);
      chk_conf("midrst_conflict", 1'b0);
      tick();
      chk_val("midrst_hold40", 3, 77);
      idle_inputs();
      #1;
      chk_val("midrst_no_write40", 3, 0);
      reset = 1'b0;
      tick();
      chk_val("post_rst_val5", 1, 0);
      chk_rdy("post_rst_rdy5", 1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_write_readback();
      test_alloc_ready();
      test_alloc_write_same();
      test_preg0();
      test_collision();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/phy_regfile_mp.md
Name: phy_regfile_mp

Overview:
- Parametrised multi-port physical register file for the OOO core, successor to the fixed 2-read register file.
- Provides N read ports, one write port per functional unit, and write-to-read bypass.
- Holds a per-register ready bit (scoreboard) that rename clears on allocation and writeback sets.
- Sits between rename/issue (reads, allocation) and the FU writeback bus.

Parameters:
- NUM_PREG, 64, number of physical registers; preg 0 is hardwired zero.
- PREG_W, $clog2(NUM_PREG), physical register index width.
- VAL_W, 32, register value width.
- NUM_RD, 4, number of read ports.
- NUM_WR, 3, number of write ports (one per FU).
- NUM_ALLOC, 2, number of rename allocation ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_preg  in  NUM_RD*PREG_W  read index per port.
- rd_val  out  NUM_RD*VAL_W  read data per port.
- rd_ready  out  NUM_RD  ready bit of the register addressed by each read port.
- wr_en  in  NUM_WR  write enable per FU.
- wr_preg  in  NUM_WR*PREG_W  write index per FU.
- wr_val  in  NUM_WR*VAL_W  write data per FU.
- alloc_en  in  NUM_ALLOC  allocation valid per rename slot.
- alloc_preg  in  NUM_ALLOC*PREG_W  newly allocated destination register.
- wr_conflict  out  1  registered sticky flag: two enabled write ports targeted the same nonzero preg.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state, applied immediately on assertion and held while reset=1:
  - all registers = 0;
  - all ready bits = 1;
  - wr_conflict = 0.
- Read path (combinational, zero latency):
  - rd_val = array[rd_preg] unless bypassed.
  - Bypass: if any wr_en[j]=1 and wr_preg[j]=rd_preg[i]≠0, rd_val[i]=wr_val[j] from the lowest such j, in the same cycle.
  - rd_preg=0 -> rd_val=0 and rd_ready=1, always.
- Write path:
  - On the rising edge, array[wr_preg[j]] <= wr_val[j] for each enabled j with wr_preg[j]≠0.
  - Writes to preg 0 are dropped.
- Write priority: if several enabled ports hit the same preg, the lowest port index wins, in both the array and the bypass.
- Conflict flag: on such a collision (nonzero preg), wr_conflict <= 1 at the edge and stays 1 until reset.
- Ready bits:
  - Enabled write to p≠0 sets ready[p] at the edge.
  - alloc_en[k] with alloc_preg[k]≠0 clears ready[alloc_preg[k]] at the edge.
  - Allocation and write to the same preg in one cycle: allocation wins, ready=0, but the data is still written.
  - Two allocations of the same preg: ready=0. This is legal and not flagged.
- rd_ready (combinational):
  - If any enabled write targets rd_preg[i]≠0 this cycle, rd_ready[i]=1 (bypass).
  - Otherwise rd_ready[i]=ready[rd_preg[i]].
  - Same-cycle allocation is not reflected until the next cycle.
- Index range: out-of-range indices (≥NUM_PREG) are a don't-care for reads and are ignored for writes and allocation.
- Reset mid-cycle: asynchronous clear wins over any concurrent write or allocation. Reads reflect reset values combinationally, plus bypass of any active write.

Decomposition:
- phy_regfile_pkg holds:
  - PREG_W and VAL_W defaults, and the NUM_RD, NUM_WR and NUM_ALLOC defaults;
  - typedef preg_idx_t = logic[PREG_W-1:0];
  - typedef reg_val_t = logic[VAL_W-1:0].
- Sub-module phy_regfile_bypass_rd: one instance per read port. It is a priority match across the write ports that yields rd_val and rd_ready.
- Storage, ready-bit array and conflict flag remain in the top module.

Test Plan:
- Reset then read: reset=1 for 20ns, release; read preg 21 and 23 -> rd_val=0, rd_ready=1; assert reset again mid-run -> all values 0 and ready=1 immediately, without waiting for an edge.
- Write and read-back: wr_en[0]=1, preg 23, val 144; same cycle, read preg 23 -> bypass 144; next cycle with wr_en=0 -> 144 from the array.
- Allocation and ready: alloc preg 22 -> rd_ready=0 next cycle. FU1 writes 109 to preg 22 -> rd_ready=1 and rd_val=109 in the same cycle, and held in later cycles.
- Simultaneous allocation and write to preg 5 with val 7 -> array holds 7, ready[5]=0 after the edge.
- Write collision: FU0 writes 11 and FU2 writes 33 to preg 9 -> rd_val=11 (bypass and stored); wr_conflict=1 after the edge and sticky until reset.
- Preg 0: write 55 to preg 0 on all FUs and allocate preg 0 -> reads return 0, rd_ready=1, wr_conflict stays 0.
